// File: rtl/decode_stage.sv
// Registered RV32I decode stage: classifies and field-extracts each accepted
// instruction, then queues the decoded record in a DEPTH-entry FIFO toward issue.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [9:0]       out_func,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_imm,
  output logic [CNT_W-1:0] ill_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [9:0]  dec_func;
  logic [2:0]  dec_fmt;
  logic [31:0] dec_imm32;
  logic [2:0]  funct3;
  logic [XLEN-1:0] dec_imm;

  assign funct3 = in_instr[14:12];

  always_comb begin
    dec_rs1   = 5'd0;
    dec_rs2   = 5'd0;
    dec_rd    = 5'd0;
    dec_func  = 10'd0;
    dec_fmt   = FMT_ILL;
    dec_imm32 = 32'd0;
    case (in_instr[6:0])
      7'b0110011: begin
        dec_fmt  = FMT_R;
        dec_rs1  = in_instr[19:15];
        dec_rs2  = in_instr[24:20];
        dec_rd   = in_instr[11:7];
        dec_func = {in_instr[31:25], funct3};
      end
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_fmt   = FMT_I;
        dec_rs1   = in_instr[19:15];
        dec_rd    = in_instr[11:7];
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        // shift-immediates carry funct7 like register ops
        if (in_instr[6:0] == 7'b0010011 && (funct3 == 3'b001 || funct3 == 3'b101))
          dec_func = {in_instr[31:25], funct3};
        else
          dec_func = {7'b0, funct3};
      end
      7'b0100011: begin
        dec_fmt   = FMT_S;
        dec_rs1   = in_instr[19:15];
        dec_rs2   = in_instr[24:20];
        dec_func  = {7'b0, funct3};
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt   = FMT_B;
        dec_rs1   = in_instr[19:15];
        dec_rs2   = in_instr[24:20];
        dec_func  = {7'b0, funct3};
        dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt   = FMT_U;
        dec_rd    = in_instr[11:7];
        dec_imm32 = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt   = FMT_J;
        dec_rd    = in_instr[11:7];
        dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  assign dec_imm = XLEN'($signed(dec_imm32));

  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [4:0]      rs1_q  [DEPTH];
  logic [4:0]      rs2_q  [DEPTH];
  logic [4:0]      rd_q   [DEPTH];
  logic [9:0]      func_q [DEPTH];
  logic [2:0]      fmt_q  [DEPTH];
  logic [XLEN-1:0] imm_q  [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        rs1_q[i]  <= '0;
        rs2_q[i]  <= '0;
        rd_q[i]   <= '0;
        func_q[i] <= '0;
        fmt_q[i]  <= '0;
        imm_q[i]  <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_q[wr_ptr]   <= in_pc;
        rs1_q[wr_ptr]  <= dec_rs1;
        rs2_q[wr_ptr]  <= dec_rs2;
        rd_q[wr_ptr]   <= dec_rd;
        func_q[wr_ptr] <= dec_func;
        fmt_q[wr_ptr]  <= dec_fmt;
        imm_q[wr_ptr]  <= dec_imm;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (!push && pop)
        count <= count - CW'(1);
    end
  end

  // a push cancelled by flush never entered the queue, so it is not counted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ill_cnt <= '0;
    else if (push && !flush && dec_fmt == FMT_ILL && ill_cnt != '1)
      ill_cnt <= ill_cnt + CNT_W'(1);
  end

  assign out_pc   = pc_q[rd_ptr];
  assign out_rs1  = rs1_q[rd_ptr];
  assign out_rs2  = rs2_q[rd_ptr];
  assign out_rd   = rd_q[rd_ptr];
  assign out_func = func_q[rd_ptr];
  assign out_fmt  = fmt_q[rd_ptr];
  assign out_imm  = imm_q[rd_ptr];

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a decode vector table streamed back-to-back,
// then hand-written backpressure, saturation, flush and reset sequences.
module tb_decode_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_pc, a_out_imm;
  logic [4:0]  a_out_rs1, a_out_rs2, a_out_rd;
  logic [9:0]  a_out_func;
  logic [2:0]  a_out_fmt;
  logic [15:0] a_ill_cnt;

  logic        c_in_ready, c_out_valid;
  logic [31:0] c_out_pc, c_out_imm;
  logic [4:0]  c_out_rs1, c_out_rs2, c_out_rd;
  logic [9:0]  c_out_func;
  logic [2:0]  c_out_fmt;
  logic [1:0]  c_ill_cnt;

  logic        x_in_ready, x_out_valid;
  logic [63:0] x_out_pc, x_out_imm;
  logic [4:0]  x_out_rs1, x_out_rs2, x_out_rd;
  logic [9:0]  x_out_func;
  logic [2:0]  x_out_fmt;
  logic [15:0] x_ill_cnt;

  decode_stage #(.XLEN(32), .DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
    .out_rs1(a_out_rs1), .out_rs2(a_out_rs2), .out_rd(a_out_rd),
    .out_func(a_out_func), .out_fmt(a_out_fmt), .out_imm(a_out_imm),
    .ill_cnt(a_ill_cnt));

  decode_stage #(.XLEN(32), .DEPTH(2), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .flush(flush),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_pc(c_out_pc),
    .out_rs1(c_out_rs1), .out_rs2(c_out_rs2), .out_rd(c_out_rd),
    .out_func(c_out_func), .out_fmt(c_out_fmt), .out_imm(c_out_imm),
    .ill_cnt(c_ill_cnt));

  decode_stage #(.XLEN(64), .DEPTH(2), .CNT_W(16)) dut_x (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(x_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(x_out_valid), .out_ready(out_ready), .out_pc(x_out_pc),
    .out_rs1(x_out_rs1), .out_rs2(x_out_rs2), .out_rd(x_out_rd),
    .out_func(x_out_func), .out_fmt(x_out_fmt), .out_imm(x_out_imm),
    .ill_cnt(x_ill_cnt));

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [9:0]  func;
    logic [2:0]  fmt;
    logic [31:0] imm;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_ill;

  initial begin
    //            instr         pc            rs1    rs2    rd      func     fmt   imm
    vecs[0]  = '{32'h002081B3, 32'h100, 5'd1, 5'd2, 5'd3,  10'h000, 3'd0, 32'h00000000};
    vecs[1]  = '{32'hFFF00293, 32'h104, 5'd0, 5'd0, 5'd5,  10'h000, 3'd1, 32'hFFFFFFFF};
    vecs[2]  = '{32'h0020A423, 32'h108, 5'd1, 5'd2, 5'd0,  10'h002, 3'd2, 32'h00000008};
    vecs[3]  = '{32'hFE000EE3, 32'h10C, 5'd0, 5'd0, 5'd0,  10'h000, 3'd3, 32'hFFFFFFFC};
    vecs[4]  = '{32'h123453B7, 32'h110, 5'd0, 5'd0, 5'd7,  10'h000, 3'd4, 32'h12345000};
    vecs[5]  = '{32'h00C000EF, 32'h114, 5'd0, 5'd0, 5'd1,  10'h000, 3'd5, 32'h0000000C};
    vecs[6]  = '{32'h40315093, 32'h118, 5'd2, 5'd0, 5'd1,  10'h105, 3'd1, 32'h00000403};
    vecs[7]  = '{32'hFFF17093, 32'h11C, 5'd2, 5'd0, 5'd1,  10'h007, 3'd1, 32'hFFFFFFFF};
    vecs[8]  = '{32'hFFC12083, 32'h120, 5'd2, 5'd0, 5'd1,  10'h002, 3'd1, 32'hFFFFFFFC};
    vecs[9]  = '{32'hFFFFF117, 32'h124, 5'd0, 5'd0, 5'd2,  10'h000, 3'd4, 32'hFFFFF000};
    vecs[10] = '{32'h00000000, 32'h128, 5'd0, 5'd0, 5'd0,  10'h000, 3'd7, 32'h00000000};
    vecs[11] = '{32'hFFFFFFFF, 32'h12C, 5'd0, 5'd0, 5'd0,  10'h000, 3'd7, 32'h00000000};
    vecs[12] = '{32'h80000093, 32'h130, 5'd0, 5'd0, 5'd1,  10'h000, 3'd1, 32'hFFFFF800};
    vecs[13] = '{32'h00008067, 32'h134, 5'd1, 5'd0, 5'd0,  10'h000, 3'd1, 32'h00000000};
    vecs[14] = '{32'h00209463, 32'h138, 5'd1, 5'd2, 5'd0,  10'h001, 3'd3, 32'h00000008};
    vecs[15] = '{32'h30002573, 32'h13C, 5'd0, 5'd0, 5'd10, 10'h002, 3'd1, 32'h00000300};

    rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst out_valid", 64'(a_out_valid), 64'd0);
    chk("rst in_ready",  64'(a_in_ready),  64'd1);
    chk("rst out_fmt",   64'(a_out_fmt),   64'd0);
    chk("rst out_imm",   64'(a_out_imm),   64'd0);
    chk("rst out_pc",    64'(a_out_pc),    64'd0);
    chk("rst out_rd",    64'(a_out_rd),    64'd0);
    chk("rst ill_cnt",   64'(a_ill_cnt),   64'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // streamed table: each vector is pushed while its predecessor pops
    out_ready = 1'b1;
    exp_ill = 0;
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = {32'h0, vecs[i].pc};
      step();
      if (vecs[i].fmt == 3'd7) exp_ill++;
      chk($sformatf("v%0d out_valid", i), 64'(a_out_valid), 64'd1);
      chk($sformatf("v%0d in_ready", i),  64'(a_in_ready),  64'd1);
      chk($sformatf("v%0d pc", i),   64'(a_out_pc),   64'(vecs[i].pc));
      chk($sformatf("v%0d rs1", i),  64'(a_out_rs1),  64'(vecs[i].rs1));
      chk($sformatf("v%0d rs2", i),  64'(a_out_rs2),  64'(vecs[i].rs2));
      chk($sformatf("v%0d rd", i),   64'(a_out_rd),   64'(vecs[i].rd));
      chk($sformatf("v%0d func", i), 64'(a_out_func), 64'(vecs[i].func));
      chk($sformatf("v%0d fmt", i),  64'(a_out_fmt),  64'(vecs[i].fmt));
      chk($sformatf("v%0d imm", i),  64'(a_out_imm),  64'(vecs[i].imm));
      chk($sformatf("v%0d imm64", i), x_out_imm, {{32{vecs[i].imm[31]}}, vecs[i].imm});
      chk($sformatf("v%0d ill_cnt", i), 64'(a_ill_cnt), 64'(exp_ill));
      chk($sformatf("v%0d ill_cnt2", i), 64'(c_ill_cnt), 64'(exp_ill > 3 ? 3 : exp_ill));
    end
    in_valid = 1'b0;
    step();
    chk("drain out_valid", 64'(a_out_valid), 64'd0);
    chk("drain in_ready",  64'(a_in_ready),  64'd1);

    // four more illegals: narrow counter must hold at all-ones
    in_valid = 1'b1;
    in_instr = 32'h00000000;
    for (int i = 0; i < 4; i++) begin
      in_pc = 64'h140 + 64'(4 * i);
      step();
      exp_ill++;
    end
    in_valid = 1'b0;
    chk("sat ill_cnt16", 64'(a_ill_cnt), 64'(exp_ill));
    chk("sat ill_cnt2",  64'(c_ill_cnt), 64'd3);
    step();

    // backpressure: third offer must wait, and full stays not-ready during a pop
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h002081B3;
    in_pc     = 64'h200;
    step();
    chk("bp1 in_ready", 64'(a_in_ready), 64'd1);
    chk("bp1 head pc",  64'(a_out_pc),   64'h200);
    in_pc = 64'h204;
    step();
    chk("bp2 in_ready",  64'(a_in_ready),  64'd0);
    chk("bp2 out_valid", 64'(a_out_valid), 64'd1);
    chk("bp2 head pc",   64'(a_out_pc),    64'h200);
    in_pc = 64'h208;
    step();
    chk("bp3 in_ready", 64'(a_in_ready), 64'd0);
    chk("bp3 head pc",  64'(a_out_pc),   64'h200);
    out_ready = 1'b1;
    step();
    chk("bp4 head pc",  64'(a_out_pc),   64'h204);
    chk("bp4 in_ready", 64'(a_in_ready), 64'd1);
    step();
    chk("bp5 head pc",   64'(a_out_pc),    64'h208);
    chk("bp5 out_valid", 64'(a_out_valid), 64'd1);
    in_valid = 1'b0;
    step();
    chk("bp6 out_valid", 64'(a_out_valid), 64'd0);

    // flush with a full queue overrides a simultaneous push and pop
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00000000;
    in_pc     = 64'h300;
    step();
    exp_ill++;
    in_instr = 32'h002081B3;
    in_pc    = 64'h304;
    step();
    chk("fl full in_ready", 64'(a_in_ready), 64'd0);
    in_pc     = 64'h308;
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("fl out_valid", 64'(a_out_valid), 64'd0);
    chk("fl in_ready",  64'(a_in_ready),  64'd1);
    chk("fl ill_cnt",   64'(a_ill_cnt),   64'(exp_ill));
    in_valid = 1'b1;
    in_pc    = 64'h30C;
    step();
    in_valid = 1'b0;
    chk("fl next pc",    64'(a_out_pc),    64'h30C);
    chk("fl next valid", 64'(a_out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    chk("fl single entry", 64'(a_out_valid), 64'd0);

    // asynchronous reset mid-traffic, then push on first edge after release
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00293;
    in_pc     = 64'h400;
    step();
    in_pc = 64'h404;
    step();
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst out_valid", 64'(a_out_valid), 64'd0);
    chk("arst in_ready",  64'(a_in_ready),  64'd1);
    chk("arst out_pc",    64'(a_out_pc),    64'd0);
    chk("arst out_imm",   64'(a_out_imm),   64'd0);
    chk("arst out_fmt",   64'(a_out_fmt),   64'd0);
    chk("arst ill_cnt",   64'(a_ill_cnt),   64'd0);
    in_valid = 1'b1;
    in_instr = 32'h002081B3;
    in_pc    = 64'h500;
    step();
    chk("arst held", 64'(a_out_valid), 64'd0);
    rst = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rel out_valid", 64'(a_out_valid), 64'd1);
    chk("rel out_pc",    64'(a_out_pc),    64'h500);
    chk("rel out_rd",    64'(a_out_rd),    64'd3);
    out_ready = 1'b1;
    step();
    chk("rel drained", 64'(a_out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised successor to the combinational RV32I instruction decoder. Accepts fetched instructions with their PC over a valid/ready handshake. Classifies each by format, extracts register indices and function code, and builds a sign-extended XLEN immediate. Results are buffered in a DEPTH-entry FIFO toward the issue stage; the block supports pipeline flush and counts illegal encodings.

## Interface
- XLEN, 32, width of PC and immediate output (32 or 64)
- DEPTH, 2, FIFO entries, power of two, ≥2
- CNT_W, 16, width of illegal-instruction counter
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction address
- flush  in  1  synchronous discard of all buffered entries
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_pc  out  XLEN  PC of head entry
- out_rs1, out_rs2, out_rd  out  5 each  register indices
- out_func  out  10  function code
- out_fmt  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5, illegal=7
- out_imm  out  XLEN  sign-extended immediate
- ill_cnt  out  CNT_W  saturating count of accepted illegal instructions

## Operation
- Legal opcodes (instr[6:0]):
  - R: 0110011
  - I: 0010011, 0000011, 1100111, 1110011
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
- Anything else is illegal: fmt=7, all other fields 0.
- Field zeroing:
  - rd=0 for S/B.
  - rs1=0 for U/J.
  - rs2=0 for I/U/J.
- func:
  - R: {instr[31:25], instr[14:12]}.
  - I with opcode 0010011 and funct3 001/101: same as R.
  - Other I, S, B: {7'b0, funct3}.
  - U/J: 0.
- Immediates, sign-extended from the top bit to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U: {instr[31:12], 12'b0}.
  - R: 0.
- FIFO with read pointer, write pointer and occupancy count; pointers wrap modulo DEPTH.
- Handshake:
  - in_ready = (count < DEPTH); push occurs when in_valid & in_ready.
  - out_valid = (count > 0); pop occurs when out_valid & out_ready.
- Simultaneous push and pop: count unchanged, both pointers advance. Allowed at any non-full count.
- When full, in_ready is 0 even if a pop occurs the same cycle; there is no full-bypass.
- flush:
  - Next cycle: count=0 and pointers=0. Flush overrides any push or pop that cycle.
  - ill_cnt is not modified by flush.
- ill_cnt increments on each push with fmt=7 and saturates at all-ones. Flushed illegal entries remain counted.
- out_* always show the head entry. When empty they hold the last-written contents; only out_valid qualifies them.

## Timing
- Reset (rst low, asynchronous):
  - count, pointers and ill_cnt become 0; all storage entries cleared.
  - Hence out_valid=0, in_ready=1, and every out_* field is 0 (out_fmt=0).
- Latency: an instruction pushed at edge N appears with out_valid=1 after edge N when the FIFO was empty; throughput is 1/cycle.
- Reset release mid-traffic: the first push is accepted on the first rising edge with rst high.
- Reset asserted mid-operation discards all entries immediately.
- in_ready and out_valid are registered-state functions only; there is no combinational path from out_ready or in_valid to them.

## Test plan
- Reset, then push 0x002081B3 (add x3,x1,x2) at pc 0x100 → one cycle later: out_valid=1, rs1=1, rs2=2, rd=3, func=0, fmt=0, imm=0, out_pc=0x100.
- Push 0xFFF00293 (addi x5,x0,-1), 0x0020A423 (sw x2,8(x1)), 0xFE000EE3 (beq -4), 0x123453B7 (lui x7,0x12345) back-to-back with out_ready=1 → expected outputs in order:
  - addi: rd=5, imm=0xFFFFFFFF, fmt=1.
  - sw: rs1=1, rs2=2, rd=0, func=0x002, imm=8, fmt=2.
  - beq: imm=0xFFFFFFFC, fmt=3.
  - lui: rd=7, imm=0x12345000, fmt=4, rs1=0.
- DEPTH=2, out_ready=0, offer 3 instructions → in_ready drops after the second; raise out_ready → the third is accepted and order is preserved.
- Push 0x00000000 → fmt=7, all fields 0, ill_cnt=1. Then with CNT_W=2, push 4 more illegals → ill_cnt holds at 3.
- Fill FIFO, assert flush together with in_valid and out_ready → next cycle count=0, out_valid=0, in_ready=1, and neither the push nor the pop took effect.
- XLEN=64, push addi x1,x0,-2048 (0x80000093) → imm=0xFFFFFFFFFFFFF800.
